// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared edge-class types, defaults and classifier for the strength window
package definitions_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_WEAK   = 2'b01,
    CLS_STRONG = 2'b10
  } edge_cls_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sw_state_t;

  localparam int         DEF_IMG_W   = 640;
  localparam int         DEF_IMG_H   = 480;
  localparam logic [7:0] DEF_LOW_TH  = 8'd40;
  localparam logic [7:0] DEF_HIGH_TH = 8'd100;
  localparam int         STR_W       = 18;

  function automatic edge_cls_t classify(input logic [7:0] m,
                                         input logic [7:0] low_th,
                                         input logic [7:0] high_th);
    if (m >= high_th) return CLS_STRONG;
    if (m >= low_th) return CLS_WEAK;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - DEPTH-long delay line with shift enable, built as a circular RAM
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;

  // The slot about to be overwritten holds the sample written DEPTH shifts ago.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/strength_window.sv
// rtl/strength_window.sv - classifies NMS magnitudes and emits a zero-padded 3x3 class window per pixel
module strength_window
  import definitions_pkg::*;
#(
  parameter int         IMG_W   = DEF_IMG_W,
  parameter int         IMG_H   = DEF_IMG_H,
  parameter logic [7:0] LOW_TH  = DEF_LOW_TH,
  parameter logic [7:0] HIGH_TH = DEF_HIGH_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       mag,
  input  logic             mag_valid,
  output logic             mag_ready,
  output logic [STR_W-1:0] strength,
  output logic             str_valid
);

  localparam int PIX = IMG_W * IMG_H;
  localparam int CW  = $clog2(PIX);
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);

  localparam logic [CW-1:0] FILL_LAST = CW'(IMG_W);
  localparam logic [CW-1:0] IN_LAST   = CW'(PIX - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

  sw_state_t state, state_nxt;

  logic          accept;
  logic          shift_en;
  logic          out_en;
  logic [1:0]    cls_in;
  logic [1:0]    lb1_out, lb2_out;
  logic [CW-1:0] in_cnt;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  // Columns indexed by window row: 0 = line above, 2 = line below the centre.
  logic [1:0] col_l [3];
  logic [1:0] col_m [3];
  logic [1:0] col_r [3];
  logic [1:0] win   [9];
  logic [STR_W-1:0] win_masked;

  always_comb begin
    state_nxt = state;
    mag_ready = 1'b1;
    out_en    = 1'b0;
    case (state)
      ST_FILL: begin
        if (mag_valid && in_cnt == FILL_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        out_en = mag_valid;
        if (mag_valid && in_cnt == IN_LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        mag_ready = 1'b0;
        out_en    = 1'b1;
        if (cx == X_LAST && cy == Y_LAST) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  assign accept   = mag_valid & mag_ready;
  assign shift_en = accept | (state == ST_DRAIN);
  assign cls_in   = (state == ST_DRAIN) ? CLS_NONE : classify(mag, LOW_TH, HIGH_TH);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  line_buffer #(.DEPTH(IMG_W), .DW(2)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .din  (cls_in),
    .dout (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .DW(2)) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  // The incoming pixel sits at the bottom-right of the window being emitted.
  always_comb begin
    col_r[0] = lb2_out;
    col_r[1] = lb1_out;
    col_r[2] = cls_in;
    for (int r = 0; r < 3; r++) begin
      win[3*r]     = col_l[r];
      win[3*r + 1] = col_m[r];
      win[3*r + 2] = col_r[r];
    end
  end

  always_comb begin
    win_masked = '0;
    for (int i = 0; i < 9; i++) begin
      if (!((i < 3 && cy == '0) || (i >= 6 && cy == Y_LAST) ||
            (i % 3 == 0 && cx == '0) || (i % 3 == 2 && cx == X_LAST)))
        win_masked[2*i +: 2] = win[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        col_l[r] <= CLS_NONE;
        col_m[r] <= CLS_NONE;
      end
    end else if (shift_en) begin
      col_l <= col_m;
      col_m <= col_r;
    end
  end

  // in_cnt tracks input pixels; cx/cy track the centre of the next window out.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
      cx     <= '0;
      cy     <= '0;
    end else begin
      if (accept) in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
      if (out_en) begin
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strength  <= '0;
      str_valid <= 1'b0;
    end else begin
      str_valid <= out_en;
      if (out_en) strength <= win_masked;
    end
  end

endmodule

// File: tb/tb_strength_window.sv
// tb/tb_strength_window.sv - randomized self-checking bench for strength_window on a 4x3 image
module tb_strength_window;

  localparam int         W    = 4;
  localparam int         H    = 3;
  localparam int         N    = W * H;
  localparam logic [7:0] LOW  = 8'd50;
  localparam logic [7:0] HIGH = 8'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mag;
  logic        mag_valid;
  logic        mag_ready;
  logic [17:0] strength;
  logic        str_valid;

  int          errors;
  int          checks;
  int          out_n;
  int          ready_low;
  int          acc_q[$];
  logic [17:0] got_w [64];

  strength_window #(.IMG_W(W), .IMG_H(H), .LOW_TH(LOW), .HIGH_TH(HIGH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mag       (mag),
    .mag_valid (mag_valid),
    .mag_ready (mag_ready),
    .strength  (strength),
    .str_valid (str_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic int cls_of(input int m);
    if (m >= int'(HIGH)) return 2;
    if (m >= int'(LOW)) return 1;
    return 0;
  endfunction

  // Window of frame f centred on pixel p, straight from the stored image.
  function automatic int model_window(input int f, input int p);
    int r, c, rr, cc, idx, w;
    r = p / W;
    c = p % W;
    w = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        idx = f * N + rr * W + cc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W && idx < acc_q.size())
          w = w | (cls_of(acc_q[idx]) << (2 * (3 * (dr + 1) + (dc + 1))));
      end
    end
    return w;
  endfunction

  always @(negedge clk) begin
    int f, p, need, n11;
    if (!rst) begin
      if (!mag_ready) ready_low++;
      if (str_valid) begin
        f = out_n / N;
        p = out_n % N;
        chk("window", int'(strength), model_window(f, p));
        need = (p + W + 2 <= N) ? f * N + p + W + 2 : (f + 1) * N;
        chk("latency_accepts", acc_q.size(), need);
        n11 = 0;
        for (int i = 0; i < 9; i++) if (strength[2*i +: 2] == 2'b11) n11++;
        chk("no_code11", n11, 0);
        if (out_n < 64) got_w[out_n] = strength;
        out_n++;
      end
      if (mag_valid && mag_ready) acc_q.push_back(int'(mag));
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    mag_valid = 1'b0;
    acc_q.delete();
    out_n     = 0;
    @(posedge clk); #1;
    chk("rst_str_valid", int'(str_valid), 0);
    chk("rst_strength", int'(strength), 0);
    chk("rst_mag_ready", int'(mag_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] v, input int gap_pct);
    bit done;
    int tries;
    done  = 1'b0;
    tries = 0;
    mag   = v;
    while (!done) begin
      mag_valid = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      done = mag_valid && mag_ready;
      @(posedge clk); #1;
      tries++;
      if (!done && tries > 500) begin
        checks++;
        errors++;
        $display("FAIL px_timeout: got no accept after %0d cycles required accept", tries);
        done = 1'b1;
      end
    end
    mag_valid = 1'b0;
  endtask

  // mode 0: every pixel = v; mode 1: random; mode 2: pixel (1,1) = v, rest 0
  task automatic send_frame(input int mode, input logic [7:0] v, input int gap_pct);
    logic [7:0] px;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       px = v;
        1:       px = 8'($urandom_range(255));
        default: px = (i == W + 1) ? v : 8'd0;
      endcase
      send_px(px, gap_pct);
    end
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_n < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("window_count", out_n, target);
  endtask

  task automatic check_full_frame();
    chk("ready_low_cycles", ready_low, W + 1);
    chk("win_0_0", int'(got_w[0]), 'h28A00);
    chk("win_1_1", int'(got_w[5]), 'h2AAAA);
    chk("win_2_3", int'(got_w[11]), 'h0028A);
  endtask

  initial begin
    int thr_mag [5];
    int thr_cls [5];
    thr_mag = '{49, 50, 99, 100, 255};
    thr_cls = '{0, 1, 1, 2, 2};
    errors    = 0;
    checks    = 0;
    ready_low = 0;
    mag       = 8'd0;
    mag_valid = 1'b0;
    do_reset();

    ready_low = 0;
    send_frame(0, 8'hFF, 0);
    wait_out(N);
    check_full_frame();

    for (int k = 0; k < 5; k++) begin
      do_reset();
      send_frame(2, 8'(thr_mag[k]), 0);
      wait_out(N);
      chk("centre_class", int'(got_w[5][9:8]), thr_cls[k]);
    end

    do_reset();
    send_frame(1, 8'd0, 30);
    send_frame(1, 8'd0, 30);
    wait_out(2 * N);

    do_reset();
    send_frame(0, 8'hFF, 0);
    send_frame(0, 8'h00, 0);
    wait_out(2 * N);
    for (int j = N; j < 2 * N; j++) chk("frame2_zero", int'(got_w[j]), 0);

    do_reset();
    for (int i = 0; i < 7; i++) send_px(8'hFF, 0);
    do_reset();
    ready_low = 0;
    send_frame(0, 8'hFF, 0);
    wait_out(N);
    check_full_frame();

    do_reset();
    for (int k = 0; k < 4; k++) send_frame(1, 8'd0, 10 * k);
    wait_out(4 * N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
